turtle_cpu: RTL and testbench

Single-cycle 8-bit accumulator CPU for the Turtle board, top level of the FPGA design. It fetches 16-bit instructions from an internal 4096-word instruction ROM, executes ALU, register, memory and branch instructions, and holds state in an accumulator, a 16-entry register file and a 256-byte data memory. Board controls allow free-running or single-step execution.

---
 rtl/turtle_pkg.sv | 63 ++++++
 rtl/turtle_alu.sv | 49 ++++
 rtl/turtle_cpu.sv | 167 ++++++++++++++++
 tb/tb_turtle_cpu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/turtle_pkg.sv
// Shared types, field layout and width constants for the Turtle accumulator CPU.
package turtle_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned PC_W        = 12;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned REG_ADDR_W  = 4;
  localparam int unsigned FUNC_W      = 4;
  localparam int unsigned FLAG_W      = 4;
  localparam int unsigned IMEM_DEPTH  = 4096;
  localparam int unsigned DMEM_DEPTH  = 256;
  localparam int unsigned REG_DEPTH   = 16;

  localparam logic [REG_ADDR_W-1:0] STATUS_ADDR = 4'd15;

  localparam int unsigned FLAG_ZERO     = 0;
  localparam int unsigned FLAG_POSITIVE = 1;
  localparam int unsigned FLAG_CARRY    = 2;
  localparam int unsigned FLAG_OVERFLOW = 3;

  typedef enum logic [2:0] {
    OPCODE_REG_MEMORY = 3'b000,
    OPCODE_ALU_REG    = 3'b001,
    OPCODE_ALU_IMM    = 3'b010
  } opcode_t;

  typedef enum logic [FUNC_W-1:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_INV = 4'h5
  } alu_func_t;

  typedef enum logic [FUNC_W-1:0] {
    RM_LOAD  = 4'h0,
    RM_STORE = 4'h1,
    RM_GET   = 4'h2,
    RM_PUT   = 4'h3,
    RM_SET   = 4'h4
  } reg_mem_func_t;

  typedef enum logic [2:0] {
    COND_JMP           = 3'b000,
    COND_ZERO          = 3'b001,
    COND_NOT_ZERO      = 3'b010,
    COND_POSITIVE      = 3'b011,
    COND_NEGATIVE      = 3'b100,
    COND_CARRY_SET     = 3'b101,
    COND_CARRY_CLEARED = 3'b110,
    COND_JMPR          = 3'b111
  } branch_cond_t;

  // Branches reuse op as cond and {func, low} as the 12-bit target/offset.
  typedef struct packed {
    logic                is_branch;
    logic [2:0]          op;
    logic [FUNC_W-1:0]   func;
    logic [DATA_W-1:0]   low;
  } instr_t;

endpackage

// File: rtl/turtle_alu.sv
// Combinational 8-bit ALU: result plus zero/positive/carry/overflow flags.
module turtle_alu
  import turtle_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_func_t         i_func,
  output logic [DATA_W-1:0] o_result_c,
  output logic              o_zero_c,
  output logic              o_positive_c,
  output logic              o_carry_c,
  output logic              o_overflow_c,
  output logic              o_valid_c
);

  logic [DATA_W:0] w_wide;

  // Carry on SUB is the inverted borrow, so it reads 1 when i_a >= i_b.
  always_comb begin
    w_wide       = {1'b0, i_a};
    o_carry_c    = 1'b0;
    o_overflow_c = 1'b0;
    o_valid_c    = 1'b1;
    case (i_func)
      ALU_ADD: begin
        w_wide       = {1'b0, i_a} + {1'b0, i_b};
        o_carry_c    = w_wide[DATA_W];
        o_overflow_c = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                       (w_wide[DATA_W-1] != i_a[DATA_W-1]);
      end
      ALU_SUB: begin
        w_wide       = {1'b0, i_a} - {1'b0, i_b};
        o_carry_c    = ~w_wide[DATA_W];
        o_overflow_c = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                       (w_wide[DATA_W-1] != i_a[DATA_W-1]);
      end
      ALU_AND: w_wide = {1'b0, i_a & i_b};
      ALU_OR:  w_wide = {1'b0, i_a | i_b};
      ALU_XOR: w_wide = {1'b0, i_a ^ i_b};
      ALU_INV: w_wide = {1'b0, ~i_a};
      default: o_valid_c = 1'b0;
    endcase
    o_result_c = w_wide[DATA_W-1:0];
  end

  assign o_zero_c     = (o_result_c == '0);
  assign o_positive_c = ~o_result_c[DATA_W-1];

endmodule

// File: rtl/turtle_cpu.sv
// Single-cycle 8-bit accumulator CPU. Define TURTLE_MANUAL_CLK_EN to enable
// single-step execution from the board switch/button; instruction ROM is preloaded externally.
module turtle_cpu
  import turtle_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic manual_clk_sw,
  input  logic pulse_clk_btn
);

  logic [PC_W-1:0]       r_pc;
  logic [DATA_W-1:0]     r_acc;
  logic                  w_step;
  instr_t                w_instr;
  logic [PC_W-1:0]       w_addr;
  logic [REG_ADDR_W-1:0] w_reg_addr;
  logic [DATA_W-1:0]     w_reg_rd;
  logic [DATA_W-1:0]     w_dmem_rd;
  logic [FLAG_W-1:0]     w_flags;
  logic [PC_W-1:0]       w_pc_next;
  logic                  w_taken;
  logic                  w_acc_we;
  logic [DATA_W-1:0]     w_acc_d;
  logic                  w_reg_we;
  logic [DATA_W-1:0]     w_reg_d;
  logic                  w_dmem_we;
  logic                  w_status_we;
  logic [DATA_W-1:0]     w_alu_b;
  logic [DATA_W-1:0]     w_alu_result;
  logic                  w_alu_zero;
  logic                  w_alu_positive;
  logic                  w_alu_carry;
  logic                  w_alu_overflow;
  logic                  w_alu_valid;

`ifdef TURTLE_MANUAL_CLK_EN
  logic r_btn_meta;
  logic r_btn_sync;
  logic r_btn_prev;

  // Two-flop synchronizer plus edge detector: one step per button press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_meta <= pulse_clk_btn;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
    end
  end

  assign w_step = manual_clk_sw ? (r_btn_sync & ~r_btn_prev) : 1'b1;
`else
  logic w_unused_step_ctrl;
  assign w_unused_step_ctrl = manual_clk_sw ^ pulse_clk_btn;
  assign w_step             = 1'b1;
`endif

  if (1'b1) begin : instruction_memory_inst
    logic [INSTR_W-1:0] mem [0:IMEM_DEPTH-1];
  end

  if (1'b1) begin : data_memory_inst
    logic [DATA_W-1:0] mem [0:DMEM_DEPTH-1];
    always_ff @(posedge clk) begin
      if (reset_n && w_step && w_dmem_we) mem[w_reg_rd] <= r_acc;
    end
  end

  // STATUS lives at R15; ALU flag writes and PUT R15 never coincide.
  if (1'b1) begin : register_file_inst
    logic [DATA_W-1:0] mem [0:REG_DEPTH-1];
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < REG_DEPTH; i++) mem[i] <= '0;
      end else if (w_step) begin
        if (w_reg_we)    mem[w_reg_addr]  <= w_reg_d;
        if (w_status_we) mem[STATUS_ADDR] <= {4'b0, w_alu_overflow, w_alu_carry,
                                              w_alu_positive, w_alu_zero};
      end
    end
  end

  assign w_instr    = instr_t'(instruction_memory_inst.mem[r_pc]);
  assign w_addr     = {w_instr.func, w_instr.low};
  assign w_reg_addr = w_instr.low[REG_ADDR_W-1:0];
  assign w_reg_rd   = register_file_inst.mem[w_reg_addr];
  assign w_dmem_rd  = data_memory_inst.mem[w_reg_rd];
  assign w_flags    = register_file_inst.mem[STATUS_ADDR][FLAG_W-1:0];

  turtle_alu alu_inst (
    .i_a          (r_acc),
    .i_b          (w_alu_b),
    .i_func       (alu_func_t'(w_instr.func)),
    .o_result_c   (w_alu_result),
    .o_zero_c     (w_alu_zero),
    .o_positive_c (w_alu_positive),
    .o_carry_c    (w_alu_carry),
    .o_overflow_c (w_alu_overflow),
    .o_valid_c    (w_alu_valid)
  );

  // Decoder: produces write enables, write data and the next PC.
  always_comb begin
    w_pc_next   = r_pc + PC_W'(1);
    w_taken     = 1'b0;
    w_acc_we    = 1'b0;
    w_acc_d     = r_acc;
    w_reg_we    = 1'b0;
    w_reg_d     = r_acc;
    w_dmem_we   = 1'b0;
    w_status_we = 1'b0;
    w_alu_b     = w_reg_rd;
    if (w_instr.is_branch) begin
      case (branch_cond_t'(w_instr.op))
        COND_JMP:           w_pc_next = w_addr;
        COND_ZERO:          w_taken   = w_flags[FLAG_ZERO];
        COND_NOT_ZERO:      w_taken   = ~w_flags[FLAG_ZERO];
        COND_POSITIVE:      w_taken   = w_flags[FLAG_POSITIVE];
        COND_NEGATIVE:      w_taken   = ~w_flags[FLAG_POSITIVE];
        COND_CARRY_SET:     w_taken   = w_flags[FLAG_CARRY];
        COND_CARRY_CLEARED: w_taken   = ~w_flags[FLAG_CARRY];
        default:            w_taken   = 1'b1;
      endcase
      if (w_taken) w_pc_next = r_pc + w_addr;
    end else begin
      case (opcode_t'(w_instr.op))
        OPCODE_REG_MEMORY: begin
          case (reg_mem_func_t'(w_instr.func))
            RM_LOAD:  begin w_acc_we = 1'b1; w_acc_d = w_dmem_rd;   end
            RM_STORE: w_dmem_we = 1'b1;
            RM_GET:   begin w_acc_we = 1'b1; w_acc_d = w_reg_rd;    end
            RM_PUT: begin
              w_reg_we = 1'b1;
              if (w_reg_addr == STATUS_ADDR) w_reg_d = {4'b0, r_acc[FLAG_W-1:0]};
            end
            RM_SET:   begin w_acc_we = 1'b1; w_acc_d = w_instr.low; end
            default:  ;
          endcase
        end
        OPCODE_ALU_REG, OPCODE_ALU_IMM: begin
          if (w_instr.op == OPCODE_ALU_IMM) w_alu_b = w_instr.low;
          if (w_alu_valid) begin
            w_acc_we    = 1'b1;
            w_acc_d     = w_alu_result;
            w_status_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc  <= '0;
      r_acc <= '0;
    end else if (w_step) begin
      r_pc <= w_pc_next;
      if (w_acc_we) r_acc <= w_acc_d;
    end
  end

endmodule

// File: tb/tb_turtle_cpu.sv
// Directed self-checking bench for turtle_cpu; programs are written into the ROM hierarchically.
module tb_turtle_cpu;

  logic clk = 1'b0;
  logic reset_n;
  logic manual_clk_sw;
  logic pulse_clk_btn;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [15:0] NOP = 16'h3000;

  turtle_cpu dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .manual_clk_sw (manual_clk_sw),
    .pulse_clk_btn (pulse_clk_btn)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] i_set(input logic [7:0] imm);
    return {4'h0, 4'h4, imm};
  endfunction
  function automatic logic [15:0] i_rm(input logic [3:0] f, input logic [3:0] r);
    return {4'h0, f, 4'h0, r};
  endfunction
  function automatic logic [15:0] i_alui(input logic [3:0] f, input logic [7:0] imm);
    return {4'h2, f, imm};
  endfunction
  function automatic logic [15:0] i_alur(input logic [3:0] f, input logic [3:0] r);
    return {4'h1, f, 4'h0, r};
  endfunction
  function automatic logic [15:0] i_br(input logic [2:0] c, input logic [11:0] a);
    return {1'b1, c, a};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 4096; i++) dut.instruction_memory_inst.mem[i] = NOP;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] regs_or();
    logic [7:0] v = '0;
    for (int i = 0; i < 16; i++) v |= dut.register_file_inst.mem[i];
    return v;
  endfunction

  initial begin
    reset_n       = 1'b0;
    manual_clk_sw = 1'b0;
    pulse_clk_btn = 1'b0;
    clear_imem();

    // Signed overflow on ADD.
    dut.instruction_memory_inst.mem[0] = i_set(8'h7F);
    dut.instruction_memory_inst.mem[1] = i_alui(4'h0, 8'h01);
    do_reset();
    check_eq("reset_pc", 16'(dut.r_pc), 16'h000);
    check_eq("reset_acc", 16'(dut.r_acc), 16'h00);
    check_eq("reset_regs", 16'(regs_or()), 16'h00);
    step(2);
    check_eq("add_ovf_acc", 16'(dut.r_acc), 16'h80);
    check_eq("add_ovf_status", 16'(dut.register_file_inst.mem[15]), 16'h08);
    check_eq("add_ovf_pc", 16'(dut.r_pc), 16'h002);

    // BZ taken.
    clear_imem();
    dut.instruction_memory_inst.mem[0] = i_set(8'h05);
    dut.instruction_memory_inst.mem[1] = i_alui(4'h1, 8'h05);
    dut.instruction_memory_inst.mem[2] = i_br(3'b001, 12'd3);
    do_reset();
    step(2);
    check_eq("sub_zero_acc", 16'(dut.r_acc), 16'h00);
    check_eq("sub_zero_status", 16'(dut.register_file_inst.mem[15]), 16'h07);
    step(1);
    check_eq("bz_taken_pc", 16'(dut.r_pc), 16'h005);

    // BZ not taken.
    dut.instruction_memory_inst.mem[1] = i_alui(4'h1, 8'h04);
    do_reset();
    step(3);
    check_eq("bz_not_taken_pc", 16'(dut.r_pc), 16'h003);
    check_eq("sub_one_acc", 16'(dut.r_acc), 16'h01);
    check_eq("sub_one_status", 16'(dut.register_file_inst.mem[15]), 16'h06);

    // Register and data memory round trip.
    clear_imem();
    dut.instruction_memory_inst.mem[0] = i_set(8'h42);
    dut.instruction_memory_inst.mem[1] = i_rm(4'h3, 4'd3);
    dut.instruction_memory_inst.mem[2] = i_set(8'h10);
    dut.instruction_memory_inst.mem[3] = i_rm(4'h3, 4'd4);
    dut.instruction_memory_inst.mem[4] = i_rm(4'h2, 4'd3);
    dut.instruction_memory_inst.mem[5] = i_rm(4'h1, 4'd4);
    dut.instruction_memory_inst.mem[6] = i_set(8'h00);
    dut.instruction_memory_inst.mem[7] = i_rm(4'h0, 4'd4);
    do_reset();
    step(6);
    check_eq("r3", 16'(dut.register_file_inst.mem[3]), 16'h42);
    check_eq("r4", 16'(dut.register_file_inst.mem[4]), 16'h10);
    check_eq("store_dmem", 16'(dut.data_memory_inst.mem[8'h10]), 16'h42);
    check_eq("store_keeps_status", 16'(dut.register_file_inst.mem[15]), 16'h00);
    step(2);
    check_eq("load_acc", 16'(dut.r_acc), 16'h42);

    // JMP to the last address, then sequential wrap.
    clear_imem();
    dut.instruction_memory_inst.mem[0] = i_br(3'b000, 12'hFFF);
    do_reset();
    step(1);
    check_eq("jmp_fff", 16'(dut.r_pc), 16'hFFF);
    step(1);
    check_eq("pc_wrap", 16'(dut.r_pc), 16'h000);

    // Logic ops, carry on ADD and a backward relative branch.
    clear_imem();
    dut.instruction_memory_inst.mem[0] = i_set(8'hF0);
    dut.instruction_memory_inst.mem[1] = i_alui(4'h4, 8'hFF);
    dut.instruction_memory_inst.mem[2] = i_alui(4'h5, 8'h00);
    dut.instruction_memory_inst.mem[3] = i_alui(4'h0, 8'h20);
    dut.instruction_memory_inst.mem[4] = i_br(3'b101, 12'hFFE);
    do_reset();
    step(2);
    check_eq("xor_acc", 16'(dut.r_acc), 16'h0F);
    check_eq("xor_status", 16'(dut.register_file_inst.mem[15]), 16'h02);
    step(1);
    check_eq("inv_acc", 16'(dut.r_acc), 16'hF0);
    check_eq("inv_status", 16'(dut.register_file_inst.mem[15]), 16'h00);
    step(1);
    check_eq("add_carry_acc", 16'(dut.r_acc), 16'h10);
    check_eq("add_carry_status", 16'(dut.register_file_inst.mem[15]), 16'h06);
    step(1);
    check_eq("bcs_back_pc", 16'(dut.r_pc), 16'h002);

    // ALU register operand, unused func as NOP, PUT R15 masking.
    clear_imem();
    dut.instruction_memory_inst.mem[0] = i_set(8'h03);
    dut.instruction_memory_inst.mem[1] = i_rm(4'h3, 4'd2);
    dut.instruction_memory_inst.mem[2] = i_set(8'h80);
    dut.instruction_memory_inst.mem[3] = i_alur(4'h1, 4'd2);
    dut.instruction_memory_inst.mem[4] = i_alui(4'hF, 8'h00);
    dut.instruction_memory_inst.mem[5] = i_set(8'hFF);
    dut.instruction_memory_inst.mem[6] = i_rm(4'h3, 4'd15);
    dut.instruction_memory_inst.mem[7] = i_br(3'b100, 12'd5);
    do_reset();
    step(4);
    check_eq("subr_acc", 16'(dut.r_acc), 16'h7D);
    check_eq("subr_status", 16'(dut.register_file_inst.mem[15]), 16'h0E);
    step(1);
    check_eq("bad_func_acc", 16'(dut.r_acc), 16'h7D);
    check_eq("bad_func_status", 16'(dut.register_file_inst.mem[15]), 16'h0E);
    step(2);
    check_eq("put_status", 16'(dut.register_file_inst.mem[15]), 16'h0F);
    step(1);
    check_eq("bn_not_taken_pc", 16'(dut.r_pc), 16'h008);

    // Reset in the middle of a program.
    clear_imem();
    dut.instruction_memory_inst.mem[0] = i_set(8'h55);
    dut.instruction_memory_inst.mem[1] = i_rm(4'h3, 4'd5);
    dut.instruction_memory_inst.mem[2] = i_alui(4'h0, 8'h01);
    do_reset();
    step(3);
    check_eq("pre_reset_r5", 16'(dut.register_file_inst.mem[5]), 16'h55);
    reset_n = 1'b0;
    step(1);
    check_eq("mid_reset_pc", 16'(dut.r_pc), 16'h000);
    check_eq("mid_reset_acc", 16'(dut.r_acc), 16'h00);
    check_eq("mid_reset_regs", 16'(regs_or()), 16'h00);
    check_eq("mid_reset_dmem", 16'(dut.data_memory_inst.mem[8'h10]), 16'h42);
    reset_n = 1'b1;

    // Step control.
    clear_imem();
    manual_clk_sw = 1'b1;
    do_reset();
`ifdef TURTLE_MANUAL_CLK_EN
    pulse_clk_btn = 1'b1;
    step(100);
    check_eq("manual_hold_pc", 16'(dut.r_pc), 16'h001);
    pulse_clk_btn = 1'b0;
    step(5);
    for (int p = 0; p < 2; p++) begin
      pulse_clk_btn = 1'b1;
      step(5);
      pulse_clk_btn = 1'b0;
      step(5);
    end
    check_eq("manual_total_pc", 16'(dut.r_pc), 16'h003);
`else
    pulse_clk_btn = 1'b1;
    step(10);
    pulse_clk_btn = 1'b0;
    check_eq("auto_ignores_sw_pc", 16'(dut.r_pc), 16'h00A);
`endif
    manual_clk_sw = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
